// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the unified-RAM arbiter: read-owner encoding and
// starvation counter sizing.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE  = 2'd0,
      OWN_FETCH = 2'd1,
      OWN_DATA  = 2'd2
   } owner_e;

   localparam int STARVE_MAX_DEFAULT = 4;
   localparam int STARVE_W           = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, load/store port and RAM command/response signals
// that the arbiter sits between.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic                  i_req;
   logic [ADDR_W-1:0]     i_addr;
   logic                  i_gnt;
   logic                  i_rvalid;
   logic [DATA_W-1:0]     i_rdata;

   logic                  d_req;
   logic                  d_we;
   logic [DATA_W/8-1:0]   d_be;
   logic [ADDR_W-1:0]     d_addr;
   logic [DATA_W-1:0]     d_wdata;
   logic                  d_gnt;
   logic                  d_rvalid;
   logic [DATA_W-1:0]     d_rdata;

   logic                  m_en;
   logic                  m_we;
   logic [DATA_W/8-1:0]   m_be;
   logic [ADDR_W-3:0]     m_addr;
   logic [DATA_W-1:0]     m_wdata;
   logic [DATA_W-1:0]     m_rdata;

   // The arbiter is the slave of both requesters and drives the RAM command.
   modport slave (
      input  i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
      output i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_be, m_addr, m_wdata
   );

   modport master (
      output i_req, i_addr, d_req, d_we, d_be, d_addr, d_wdata, m_rdata,
      input  i_gnt, i_rvalid, i_rdata, d_gnt, d_rvalid, d_rdata,
             m_en, m_we, m_be, m_addr, m_wdata
   );

endinterface

// File: rtl/mem_arbiter.sv
// Fixed-priority (data first) arbiter for a single-port RAM shared by fetch and
// load/store, with a starvation counter that forces a fetch grant.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
   input logic          clk,
   input logic          rst_n,
   mem_arbiter_if.slave bus
);

   localparam int BE_W = DATA_W / 8;
   localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

   logic                fetch_win;
   logic                data_win;
   owner_e              owner_q, owner_d;
   logic [STARVE_W-1:0] starve_q, starve_d;
   logic                unused_addr_lsbs;

   assign unused_addr_lsbs = ^{bus.i_addr[1:0], bus.d_addr[1:0]};

   // Grants are gated by rst_n so nothing reaches the RAM while in reset.
   always_comb begin
      fetch_win = 1'b0;
      data_win  = 1'b0;
      if (rst_n) begin
         if (starve_q == STARVE_LIM && bus.i_req) begin
            fetch_win = 1'b1;
         end else if (bus.d_req) begin
            data_win = 1'b1;
         end else if (bus.i_req) begin
            fetch_win = 1'b1;
         end
      end
   end

   always_comb begin
      bus.m_en    = 1'b0;
      bus.m_we    = 1'b0;
      bus.m_be    = '0;
      bus.m_addr  = bus.i_addr[ADDR_W-1:2];
      bus.m_wdata = bus.d_wdata;
      if (fetch_win) begin
         bus.m_en = 1'b1;
         bus.m_be = {BE_W{1'b1}};
      end else if (data_win) begin
         bus.m_en   = 1'b1;
         bus.m_we   = bus.d_we;
         bus.m_be   = bus.d_we ? bus.d_be : {BE_W{1'b1}};
         bus.m_addr = bus.d_addr[ADDR_W-1:2];
      end
   end

   always_comb begin
      starve_d = starve_q;
      owner_d  = OWN_NONE;
      if (fetch_win || !bus.i_req) begin
         starve_d = '0;
      end else if (starve_q < STARVE_LIM) begin
         starve_d = starve_q + 1'b1;
      end
      if (fetch_win) begin
         owner_d = OWN_FETCH;
      end else if (data_win && !bus.d_we) begin
         owner_d = OWN_DATA;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_q  <= OWN_NONE;
         starve_q <= '0;
      end else begin
         owner_q  <= owner_d;
         starve_q <= starve_d;
      end
   end

   assign bus.i_gnt    = fetch_win;
   assign bus.d_gnt    = data_win;
   assign bus.i_rvalid = (owner_q == OWN_FETCH);
   assign bus.d_rvalid = (owner_q == OWN_DATA);
   assign bus.i_rdata  = bus.m_rdata;
   assign bus.d_rdata  = bus.m_rdata;

endmodule
